// File: rtl/imd_val_shift_mult.sv
// Multicycle shift-add multiplier (MUL / MULHU) that keeps its partial product
// in the ID stage's two intermediate-value registers.
module imd_val_shift_mult #(
  parameter int NUM_STEPS = 32,
  parameter int IMD_W     = 34
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             operator_i,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  input  logic [IMD_W-1:0] imd_val_q_i [2],
  output logic [IMD_W-1:0] imd_val_d_o [2],
  output logic [1:0]       imd_val_we_o,
  output logic             valid_o,
  output logic [31:0]      result_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [5:0] LAST_STEP = 6'(NUM_STEPS - 1);

  state_e      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] lo, hi;
  logic [32:0] sum;

  // entry 0 holds the high accumulator, entry 1 the shrinking multiplier / low product
  assign hi  = imd_val_q_i[0][31:0];
  assign lo  = imd_val_q_i[1][31:0];
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, op_a_i} : 33'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= 6'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // outputs are forced quiet while reset is held so an aborted op never writes back
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    imd_val_d_o[0] = '0;
    imd_val_d_o[1] = '0;
    imd_val_we_o   = 2'b00;
    valid_o        = 1'b0;
    result_o       = 32'd0;
    if (rst_i) begin
      state_d = IDLE;
      count_d = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i) begin
            imd_val_d_o[1] = {{(IMD_W-32){1'b0}}, op_b_i};
            imd_val_we_o   = 2'b11;
            count_d        = 6'd0;
            state_d        = CALC;
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          if (!en_i) begin
            state_d = IDLE;
          end else begin
            imd_val_d_o[0] = {{(IMD_W-32){1'b0}}, sum[32:1]};
            imd_val_d_o[1] = {{(IMD_W-32){1'b0}}, sum[0], lo[31:1]};
            imd_val_we_o   = 2'b11;
            count_d        = count_q + 6'd1;
            if (count_q == LAST_STEP) begin
              state_d = FINISH;
            end else begin
              state_d = CALC;
            end
          end
        end
        FINISH: begin
          state_d = IDLE;
          if (en_i) begin
            valid_o  = 1'b1;
            result_o = operator_i ? hi : lo;
          end else begin
            valid_o = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = 6'd0;
        end
      endcase
    end
  end

endmodule
